// File: rtl/single_shot_sequencer.sv
// Single-shot readout sequencer: ssr init pulse, alternating counting windows
// separated by swap pulses, readout + settle, then a valid/ready result.
// Optional run/flip statistics are enabled with `define SSR_FLIP_STATS_EN.
module single_shot_sequencer #(
  parameter int PULSE_LEN     = 2,
  parameter int SETTLE_CYCLES = 4,
  parameter int WINDOW_W      = 16,
  parameter int NSWAP_W       = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [WINDOW_W-1:0] window_len,
  input  logic [NSWAP_W-1:0]  n_swaps,
  output logic                ssr,
  output logic                swap,
  output logic                readout,
  output logic                window,
  output logic                phase,
  input  logic                flip_in,
  output logic                busy,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                result_flip,
  output logic [15:0]         flip_count,
  output logic [15:0]         run_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INIT   = 3'd1,
    S_WINDOW = 3'd2,
    S_SWAP   = 3'd3,
    S_READ   = 3'd4,
    S_SETTLE = 3'd5,
    S_HOLD   = 3'd6
  } state_t;

  localparam logic [WINDOW_W-1:0] PULSE_LAST  = WINDOW_W'(PULSE_LEN - 1);
  localparam logic [WINDOW_W-1:0] SETTLE_LAST = WINDOW_W'(SETTLE_CYCLES - 1);

  state_t              state_r;
  logic [WINDOW_W-1:0] cnt_r;
  logic [WINDOW_W-1:0] wl_r;
  logic [NSWAP_W-1:0]  ns_r;
  logic [NSWAP_W-1:0]  swp_cnt_r;
  logic                handshake_s;

  assign handshake_s = (state_r == S_HOLD) && result_valid && result_ready;

  // Run sequencing FSM; every output is set on the transition into its state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= S_IDLE;
      cnt_r        <= {WINDOW_W{1'b0}};
      wl_r         <= {WINDOW_W{1'b0}};
      ns_r         <= {NSWAP_W{1'b0}};
      swp_cnt_r    <= {NSWAP_W{1'b0}};
      ssr          <= 1'b0;
      swap         <= 1'b0;
      readout      <= 1'b0;
      window       <= 1'b0;
      phase        <= 1'b0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result_flip  <= 1'b0;
    end else if (abort && (state_r != S_IDLE) && (state_r != S_HOLD)) begin
      state_r <= S_IDLE;
      cnt_r   <= {WINDOW_W{1'b0}};
      ssr     <= 1'b0;
      swap    <= 1'b0;
      readout <= 1'b0;
      window  <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            wl_r      <= (window_len == {WINDOW_W{1'b0}}) ? WINDOW_W'(1) : window_len;
            ns_r      <= n_swaps;
            swp_cnt_r <= {NSWAP_W{1'b0}};
            cnt_r     <= {WINDOW_W{1'b0}};
            ssr       <= 1'b1;
            phase     <= 1'b1;
            busy      <= 1'b1;
            state_r   <= S_INIT;
          end else begin
            state_r <= S_IDLE;
          end
        end
        S_INIT: begin
          if (cnt_r == PULSE_LAST) begin
            cnt_r   <= {WINDOW_W{1'b0}};
            ssr     <= 1'b0;
            window  <= 1'b1;
            state_r <= S_WINDOW;
          end else begin
            cnt_r <= cnt_r + WINDOW_W'(1);
          end
        end
        S_WINDOW: begin
          if (cnt_r == wl_r - WINDOW_W'(1)) begin
            cnt_r  <= {WINDOW_W{1'b0}};
            window <= 1'b0;
            if (swp_cnt_r == ns_r) begin
              readout <= 1'b1;
              state_r <= S_READ;
            end else begin
              swap      <= 1'b1;
              phase     <= ~phase;
              swp_cnt_r <= swp_cnt_r + NSWAP_W'(1);
              state_r   <= S_SWAP;
            end
          end else begin
            cnt_r <= cnt_r + WINDOW_W'(1);
          end
        end
        S_SWAP: begin
          if (cnt_r == PULSE_LAST) begin
            cnt_r   <= {WINDOW_W{1'b0}};
            swap    <= 1'b0;
            window  <= 1'b1;
            state_r <= S_WINDOW;
          end else begin
            cnt_r <= cnt_r + WINDOW_W'(1);
          end
        end
        S_READ: begin
          if (cnt_r == PULSE_LAST) begin
            cnt_r   <= {WINDOW_W{1'b0}};
            readout <= 1'b0;
            state_r <= S_SETTLE;
          end else begin
            cnt_r <= cnt_r + WINDOW_W'(1);
          end
        end
        S_SETTLE: begin
          if (cnt_r == SETTLE_LAST) begin
            cnt_r        <= {WINDOW_W{1'b0}};
            result_flip  <= flip_in;
            result_valid <= 1'b1;
            state_r      <= S_HOLD;
          end else begin
            cnt_r <= cnt_r + WINDOW_W'(1);
          end
        end
        S_HOLD: begin
          // start and abort are deliberately ignored until the host takes the result
          if (handshake_s) begin
            result_valid <= 1'b0;
            busy         <= 1'b0;
            state_r      <= S_IDLE;
          end else begin
            state_r <= S_HOLD;
          end
        end
        default: begin
          state_r <= S_IDLE;
          cnt_r   <= {WINDOW_W{1'b0}};
          ssr     <= 1'b0;
          swap    <= 1'b0;
          readout <= 1'b0;
          window  <= 1'b0;
          busy    <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

`ifdef SSR_FLIP_STATS_EN
  logic [15:0] run_count_r;
  logic [15:0] flip_count_r;

  // Saturating statistics, advanced only by a completed result handshake.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_count_r  <= 16'h0000;
      flip_count_r <= 16'h0000;
    end else if (handshake_s) begin
      if (run_count_r != 16'hFFFF) begin
        run_count_r <= run_count_r + 16'h0001;
      end else begin
        run_count_r <= run_count_r;
      end
      if (result_flip && (flip_count_r != 16'hFFFF)) begin
        flip_count_r <= flip_count_r + 16'h0001;
      end else begin
        flip_count_r <= flip_count_r;
      end
    end else begin
      run_count_r  <= run_count_r;
      flip_count_r <= flip_count_r;
    end
  end

  assign run_count  = run_count_r;
  assign flip_count = flip_count_r;
`else
  assign run_count  = 16'h0000;
  assign flip_count = 16'h0000;
`endif

endmodule

// File: doc/single_shot_sequencer.md
Name: single_shot_sequencer

Overview:
Clocked initiator that drives the single-shot readout comparator's control interface. Per run it:
- issues the `ssr` initialisation pulse;
- times alternating photon-counting windows separated by `swap` pulses;
- issues `readout`, waits for the comparator to settle, then samples `flip_in`.
The sampled result goes to the host with a valid/ready handshake. The block sits between host run control and the comparator, replacing software-timed pulse generation.

Parameters:
PULSE_LEN, 2, width in clk cycles of every ssr/swap/readout pulse (>=1)
SETTLE_CYCLES, 4, wait after readout falls before flip_in is sampled (>=1)
WINDOW_W, 16, width of window_len
NSWAP_W, 8, width of n_swaps

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  reset reset, asynchronous, active-high
start  in  1  run request, sampled in IDLE only
abort  in  1  cancel current run
window_len  in  WINDOW_W  counting window length in cycles, latched at start
n_swaps  in  NSWAP_W  number of swap pulses per run, latched at start
ssr  out  1  memory initialise pulse to comparator
swap  out  1  memory toggle pulse to comparator
readout  out  1  compare trigger to comparator
window  out  1  high while a counting window is open (photon gate)
phase  out  1  mirror of comparator current-memory index
flip_in  in  1  comparator flip output
busy  out  1  high in any state except IDLE
result_valid  out  1  result available
result_ready  in  1  host accepts result
result_flip  out  1  sampled flip value
flip_count  out  16  runs with flip=1 (optional feature)
run_count  out  16  completed runs (optional feature)

Behaviour:
- Reset: all outputs 0, FSM in IDLE, latched parameters 0. All outputs are registered.
- FSM states: IDLE, INIT, WINDOW, SWAP, READ, SETTLE, HOLD.
- IDLE:
  - start=1 latches window_len and n_swaps and clears the swap counter; next state INIT.
  - window_len=0 is latched as 1.
- INIT: ssr=1 for exactly PULSE_LEN cycles, beginning the cycle after start is sampled. phase set to 1 on entry. Then WINDOW.
- WINDOW: window=1 for exactly window_len cycles.
  - At end, if swaps issued < n_swaps, go to SWAP.
  - Otherwise go to READ.
  - Total windows per run = n_swaps+1.
- SWAP: swap=1 for PULSE_LEN cycles. phase toggles on the first swap cycle. Swap counter increments. Then WINDOW.
- READ: readout=1 for PULSE_LEN cycles. Then SETTLE.
- SETTLE: count SETTLE_CYCLES cycles.
  - On the last cycle, register flip_in into result_flip.
  - Next cycle: result_valid=1, state HOLD.
- HOLD:
  - result_valid and result_flip are held stable until result_valid&result_ready.
  - On that cycle the transfer completes, result_valid drops next cycle, and the FSM returns to IDLE.
  - busy stays 1 in HOLD; start is ignored there.
- Mutual exclusion: ssr, swap, readout and window are never high in the same cycle, and never overlap.
- Abort:
  - In any state except IDLE or HOLD, abort forces IDLE next cycle.
  - All pulses and window deassert on that same next cycle; no result is produced.
  - abort is ignored in IDLE and HOLD.
  - If start and abort are both high in IDLE, start wins.
- Counters: pulse, window and settle counters are WINDOW_W bits wide. The swap counter is NSWAP_W bits wide and is compared with ==, so there is no wrap.
- Mid-run reset: asynchronously clears everything; the comparator sees ssr/swap/readout fall immediately.

Optional Feature:
SSR_FLIP_STATS_EN:
- Defined:
  - run_count increments on each completed result handshake.
  - flip_count increments on the same handshake when result_flip=1.
  - Both counters saturate at 16'hFFFF and clear only on reset.
  - Aborted runs are not counted.
- Undefined: both ports are present and tied to 0.

Test Plan:
- PULSE_LEN=2, SETTLE=4, start at cycle 0 with window_len=10, n_swaps=3, flip_in=1 -> required response:
  - ssr high cycles 1-2; windows 3-12, 15-24, 27-36, 39-48; swaps 13-14, 25-26, 37-38;
  - readout 49-50; flip_in sampled at cycle 54; result_valid=1, result_flip=1 at cycle 55;
  - final phase=0.
- n_swaps=0, window_len=0 -> ssr cycles 1-2, single window cycle 3, readout cycles 4-5, result_valid at cycle 10.
- Hold result_ready=0 for 20 cycles after result_valid, pulsing start meanwhile -> result stable, busy=1, no new ssr. Raising ready -> IDLE the next cycle.
- Assert abort at the first cycle of the second window -> window=0 next cycle; busy=0; no readout pulse; result_valid never rises.
- Assert reset during a swap pulse -> swap, busy and phase all 0 asynchronously. A new start afterwards runs a normal sequence.
- With SSR_FLIP_STATS_EN, 3 runs with flip_in=1,0,1 plus one aborted run -> run_count=3, flip_count=2.
